tm_alu_sched: RTL
=================

Name: tm_alu_sched

Overview:
- Scheduler sharing one pipelined TM_ALU between NCORE requester cores.
- Owns the per-core transaction statistics table (AvgTxLen, InstExed) and accepts commit requests (CurTxLen) over valid/ready.
- Issues at most one operation per cycle to the ALU, tracks in-flight operations, and writes ALU results back to the table.
- Prevents read-after-write hazards on a core's table entry.

Parameters:
- NCORE, 4, number of requester cores (power of 2, ≥2).
- W, 8, stats/operand width; must match TM_ALU.
- LAT, 4, clock edges from the operand-issue edge to the edge at which the ALU result is valid for capture.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NCORE  per-core commit request.
- req_cur  in  NCORE*W  per-core CurTxLen; core i in bits [i*W +: W].
- req_ready  out  NCORE  per-core accept; a transfer occurs when valid and ready are both high at the edge.
- clr_valid  in  1  request to zero one table entry.
- clr_core  in  log2(NCORE)  entry to clear.
- clr_ready  out  1  clear accepted this cycle.
- alu_avg  out  W  registered operand to TM_ALU AvgTxLen.
- alu_inst  out  W  registered operand to TM_ALU InstExed.
- alu_cur  out  W  registered operand to TM_ALU CurTxLen.
- alu_avg_new  in  W  TM_ALU AvgTxLen_new.
- alu_inst_new  in  W  TM_ALU InstExed_new.
- rd_core  in  log2(NCORE)  table read select.
- rd_avg  out  W  combinational read of table[rd_core].avg.
- rd_inst  out  W  combinational read of table[rd_core].inst.
- done_valid  out  1  one-cycle pulse on the edge a writeback occurs.
- done_core  out  log2(NCORE)  core whose entry was written; held at its last value otherwise.

Behaviour:
- Reset (async, reset=0):
  - table avg=0, inst=0 for all cores; busy[]=0; tag pipe valid bits=0.
  - RR pointer set so that core 0 has highest priority.
  - alu_avg, alu_inst, alu_cur = 0; done_valid=0; done_core=0.
- Eligibility: core i is eligible iff req_valid[i] && !busy[i] && !(clr_valid && clr_ready && clr_core==i).
- Arbitration:
  - Round-robin among eligible cores; search starts at last granted core + 1, modulo NCORE.
  - Exactly one grant per cycle at most; req_ready[i]=1 only for the granted core (combinational).
- Issue at edge E:
  - alu_* <= {table[g].avg, table[g].inst, req_cur[g]}; busy[g] <= 1.
  - Push {valid=1, core=g} into a LAT-deep tag shift pipe; RR pointer <= g.
  - With no grant: push valid=0 and hold alu_* unchanged.
- Writeback at edge E+LAT (tag pipe output valid):
  - table[tag].avg <= alu_avg_new; table[tag].inst <= alu_inst_new; busy[tag] <= 0.
  - done_valid <= 1; done_core <= tag.
- Hazard rule:
  - A core's busy bit clears at its writeback edge, so its earliest next issue is edge E+LAT+1.
  - The operands for that issue are read from the updated table; no bypass is needed.
- Arithmetic: values are stored exactly as returned by the ALU. InstExed wraps 255→0; avg saturation is done by the ALU. The scheduler does no arithmetic.
- Clear:
  - clr_ready = !busy[clr_core]. An accepted clear zeroes the entry at the edge.
  - A clear and a grant can never target the same core in one cycle (see eligibility).
  - A clear of one core and a writeback of a different core at the same edge both take effect.
- Reset mid-operation:
  - All in-flight tags are discarded. ALU outputs returning afterwards are ignored (tag valid=0).
  - No done pulse occurs until a new issue completes.
- Throughput: up to 1 issue/cycle across cores; a single core issues at most once per LAT+1 cycles.

Decomposition:
- Package tm_sched_pkg: NCORE, W, LAT, CID_W=$clog2(NCORE), and a tag struct {valid, core}.
- Sub-module rr_arbiter (NCORE-wide, request vector + last-grant pointer in, one-hot grant + index out).
- Table, scoreboard and tag pipe stay in the top.

Test Plan:
- Reset release -> rd_avg=rd_inst=0 for every core; done_valid=0.
- Reset release with req_valid=0 -> req_ready=0 for all cores; clr_ready=1.
- Core0 req_cur=10, single request -> issue alu_avg=0, alu_inst=0, alu_cur=10. LAT edges later: done_valid=1, done_core=0; table[0] = avg 10, inst 1.
- Core0 holds req_valid with cur=10 then cur=20:
  - second request has req_ready=0 until after writeback; next issue operands are 10/1/20.
  - result avg=15, inst=2; issue spacing = LAT+1 cycles.
- All 4 cores request continuously (LAT=4):
  - grants 0,1,2,3, then one idle cycle, then 0,1,2,3 ...
  - done_core follows 0,1,2,3 with the same spacing.
- 255 commits with cur=0 on core2, then one more -> inst=255, then inst wraps to 0; other cores untouched.
- Clear and reset corner cases:
  - clr of core1 while busy -> clr_ready=0; accepted on the edge after core1's writeback; entry reads 0.
  - reset pulsed with 3 operations in flight -> table all 0; no done_valid pulses over the next 2*LAT cycles.

Source files
------------

// File: rtl/tm_sched_pkg.sv
// Shared sizing and the in-flight tag type for the TM_ALU scheduler.
package tm_sched_pkg;
    localparam int NCORE = 4;
    localparam int W     = 8;
    localparam int LAT   = 4;
    localparam int CID_W = $clog2(NCORE);

    // One slot of the in-flight tag pipe: which core's result returns this cycle
    typedef struct packed {
        logic             valid;
        logic [CID_W-1:0] core;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_vld
);
    logic [IW-1:0] w_cand;

    // First requester found walking last+1, last+2, ... wraps naturally since N is a power of 2
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_cand    = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = i_last + IW'(i);
            if (!o_gnt_vld && i_req[w_cand]) begin
                o_gnt_vld     = 1'b1;
                o_gnt_idx     = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tm_alu_sched.sv
// Shares one pipelined TM_ALU between NCORE cores; owns the per-core stats table.
module tm_alu_sched
    import tm_sched_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCORE-1:0]     req_valid,
    input  logic [NCORE*W-1:0]   req_cur,
    output logic [NCORE-1:0]     req_ready,
    input  logic                 clr_valid,
    input  logic [CID_W-1:0]     clr_core,
    output logic                 clr_ready,
    output logic [W-1:0]         alu_avg,
    output logic [W-1:0]         alu_inst,
    output logic [W-1:0]         alu_cur,
    input  logic [W-1:0]         alu_avg_new,
    input  logic [W-1:0]         alu_inst_new,
    input  logic [CID_W-1:0]     rd_core,
    output logic [W-1:0]         rd_avg,
    output logic [W-1:0]         rd_inst,
    output logic                 done_valid,
    output logic [CID_W-1:0]     done_core
);
    logic [W-1:0]     r_avg  [NCORE];
    logic [W-1:0]     r_inst [NCORE];
    logic [NCORE-1:0] r_busy;
    logic [CID_W-1:0] r_last;
    tag_t             r_tag  [LAT];

    logic             w_clr_acc;
    logic [NCORE-1:0] w_elig;
    logic [NCORE-1:0] w_gnt;
    logic [CID_W-1:0] w_gnt_idx;
    logic             w_gnt_vld;
    tag_t             w_wb;

    // A busy entry has a result in flight, so it can be neither cleared nor reissued
    assign clr_ready = !r_busy[clr_core];
    assign w_clr_acc = clr_valid && clr_ready;
    assign w_wb      = r_tag[LAT-1];
    assign req_ready = w_gnt;
    assign rd_avg    = r_avg[rd_core];
    assign rd_inst   = r_inst[rd_core];

    // Eligible cores: requesting, idle, and not being cleared this cycle
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NCORE; i++)
            w_elig[i] = req_valid[i] && !r_busy[i] && !(w_clr_acc && clr_core == CID_W'(i));
    end

    rr_arbiter #(.N(NCORE), .IW(CID_W)) u_arb (
        .i_req     (w_elig),
        .i_last    (r_last),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // Stats table and busy scoreboard; writeback, clear and issue never hit the same core
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCORE; i++) begin
                r_avg[i]  <= '0;
                r_inst[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            if (w_wb.valid) begin
                r_avg[w_wb.core]  <= alu_avg_new;
                r_inst[w_wb.core] <= alu_inst_new;
                r_busy[w_wb.core] <= 1'b0;
            end
            if (w_clr_acc) begin
                r_avg[clr_core]  <= '0;
                r_inst[clr_core] <= '0;
            end
            if (w_gnt_vld)
                r_busy[w_gnt_idx] <= 1'b1;
        end
    end

    // Operand registers, RR pointer and the tag pipe that tracks ALU latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_avg  <= '0;
            alu_inst <= '0;
            alu_cur  <= '0;
            r_last   <= CID_W'(NCORE - 1);
            for (int i = 0; i < LAT; i++)
                r_tag[i] <= '0;
        end else begin
            if (w_gnt_vld) begin
                alu_avg  <= r_avg[w_gnt_idx];
                alu_inst <= r_inst[w_gnt_idx];
                alu_cur  <= req_cur[w_gnt_idx*W +: W];
                r_last   <= w_gnt_idx;
            end
            r_tag[0] <= '{valid: w_gnt_vld, core: w_gnt_idx};
            for (int i = 1; i < LAT; i++)
                r_tag[i] <= r_tag[i-1];
        end
    end

    // Completion pulse; done_core keeps the last written core between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_valid <= 1'b0;
            done_core  <= '0;
        end else begin
            done_valid <= w_wb.valid;
            if (w_wb.valid)
                done_core <= w_wb.core;
        end
    end
endmodule
